// File: rtl/fetch_unit.sv
// fetch_unit: PC + instruction register to decode (clk, rst, instr_addr/instr ROM port, ir/ir_pc/ir_valid/ir_ready decode port, redirect/redirect_pc, halt/halted)
module fetch_unit #(
  parameter int ADDR_W = 2,
  parameter int INSTR_W = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               halted
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2;
  logic [1:0] state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic run, load, valid_n;
  always_comb begin
    run = state == RUN;
    load = run && !redirect && !halt && (!ir_valid || ir_ready);
    state_n = state == IDLE ? RUN : (run && halt) ? HALT : state;
    pc_n = (run && redirect) ? redirect_pc : load ? pc + ADDR_W'(1) : pc;
    valid_n = (run && redirect) ? 1'b0 : load ? 1'b1 : ir_valid && !ir_ready;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ir_valid <= valid_n;
      if (load) begin
        ir <= instr;
        ir_pc <= pc;
      end
    end
  end
  assign instr_addr = pc;
  assign halted = state == HALT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a cycle-level reference model
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] instr_addr, ir_pc, redirect_pc = '0;
  logic [14:0] instr, ir;
  logic ir_valid, halted, ir_ready = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [14:0] rom [4] = '{15'h610A, 15'h6150, 15'h09B0, 15'h49FA};
  int total = 0, bad = 0;
  int m_pc, m_ir_pc;
  logic [14:0] m_ir;
  bit m_valid, m_halted, m_started;
  always #5 clk = ~clk;
  assign instr = rom[instr_addr];
  fetch_unit dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted)
  );
  function automatic logic [20:0] got();
    return {ir, ir_pc, ir_valid, halted, instr_addr};
  endfunction
  function automatic logic [20:0] exp();
    return {m_ir, 2'(m_ir_pc), m_valid, m_halted, 2'(m_pc)};
  endfunction
  task automatic ref_reset();
    m_pc = 0; m_ir_pc = 0; m_ir = '0; m_valid = 0; m_halted = 0; m_started = 0;
  endtask
  task automatic ref_step();
    if (!m_started) m_started = 1;
    else if (m_halted) begin
      if (m_valid && ir_ready) m_valid = 0;
    end else if (redirect) begin
      m_pc = int'(redirect_pc); m_valid = 0; m_halted = halt;
    end else if (halt) begin
      m_halted = 1;
      if (m_valid && ir_ready) m_valid = 0;
    end else if (!m_valid || ir_ready) begin
      m_ir = rom[m_pc]; m_ir_pc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 4;
    end
  endtask
  task automatic step();
    @(posedge clk);
    ref_step();
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; redirect = 0; halt = 0; ir_ready = 0; ref_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset();
    logic [14:0] e_ir [5] = '{15'h610A, 15'h6150, 15'h09B0, 15'h49FA, 15'h610A};
    int e_pc [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; ref_reset();
    @(posedge clk); #1;
    total++; if (got() !== 21'd0) begin bad++; $display("FAIL reset_hold got=%h want=0", got()); end
    rst = 1'b0; ir_ready = 1'b1;
    step();
    total++; if (got() !== 21'd0) begin bad++; $display("FAIL reset_edge1 got=%h want=0", got()); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (ir !== e_ir[i] || ir_pc !== 2'(e_pc[i]) || ir_valid !== 1'b1 || got() !== exp()) begin
        bad++; $display("FAIL stream%0d ir=%h pc=%0d v=%b want ir=%h pc=%0d v=1", i, ir, ir_pc, ir_valid, e_ir[i], e_pc[i]);
      end
    end
  endtask
  task automatic test_backpressure();
    ir_ready = 1'b1;
    for (int i = 0; i < 8 && !(m_valid && m_ir == 15'h6150); i++) step();
    total++; if (ir !== 15'h6150) begin bad++; $display("FAIL bp_reach ir=%h want=6150", ir); end
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (ir !== 15'h6150 || ir_pc !== 2'd1 || instr_addr !== 2'd2 || ir_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold%0d ir=%h pc=%0d addr=%0d v=%b want 6150/1/2/1", i, ir, ir_pc, instr_addr, ir_valid);
      end
    end
    ir_ready = 1'b1;
    step();
    total++; if (ir !== 15'h09B0 || ir_valid !== 1'b1 || ir_pc !== 2'd2) begin bad++; $display("FAIL bp_resume ir=%h v=%b want 09B0 v=1", ir, ir_valid); end
  endtask
  task automatic test_redirect();
    ir_ready = 1'b1;
    for (int i = 0; i < 8 && !(m_valid && m_ir == 15'h610A); i++) step();
    total++; if (ir !== 15'h610A) begin bad++; $display("FAIL rd_reach ir=%h want=610A", ir); end
    redirect = 1'b1; redirect_pc = 2'd3;
    step();
    redirect = 1'b0;
    total++; if (ir_valid !== 1'b0 || instr_addr !== 2'd3) begin bad++; $display("FAIL rd_bubble v=%b addr=%0d want v=0 addr=3", ir_valid, instr_addr); end
    step();
    total++; if (ir !== 15'h49FA || ir_pc !== 2'd3 || ir_valid !== 1'b1) begin bad++; $display("FAIL rd_target ir=%h pc=%0d want 49FA/3", ir, ir_pc); end
    step();
    total++; if (ir !== 15'h610A || ir_pc !== 2'd0) begin bad++; $display("FAIL rd_wrap ir=%h pc=%0d want 610A/0", ir, ir_pc); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      ir_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 7) == 0;
      redirect_pc = 2'($urandom_range(0, 3));
      step();
      total++; if (got() !== exp()) begin bad++; $display("FAIL random%0d got=%h want=%h", i, got(), exp()); end
    end
    redirect = 1'b0;
  endtask
  task automatic test_halt();
    logic [1:0] addr;
    do_reset();
    ir_ready = 1'b1;
    repeat (3) step();
    ir_ready = 1'b0; halt = 1'b1;
    step();
    halt = 1'b0;
    total++; if (halted !== 1'b1 || ir_valid !== 1'b1 || got() !== exp()) begin bad++; $display("FAIL halt_enter h=%b v=%b want h=1 v=1", halted, ir_valid); end
    addr = instr_addr;
    step();
    total++; if (ir_valid !== 1'b1 || instr_addr !== addr) begin bad++; $display("FAIL halt_stall v=%b want=1", ir_valid); end
    ir_ready = 1'b1;
    step();
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL halt_drain v=%b want=0", ir_valid); end
    for (int i = 0; i < 5; i++) begin
      redirect = 1'b1; redirect_pc = 2'($urandom_range(0, 3)); halt = $urandom_range(0, 1) == 1;
      step();
      total++;
      if (instr_addr !== addr || halted !== 1'b1 || ir_valid !== 1'b0 || got() !== exp()) begin
        bad++; $display("FAIL halt_frozen%0d addr=%0d h=%b v=%b want addr=%0d h=1 v=0", i, instr_addr, halted, ir_valid, addr);
      end
    end
    redirect = 1'b0; halt = 1'b0;
  endtask
  task automatic test_redirect_halt();
    do_reset();
    ir_ready = 1'b1;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 2'd2; halt = 1'b1;
    step();
    redirect = 1'b0; halt = 1'b0;
    total++; if (ir_valid !== 1'b0 || instr_addr !== 2'd2 || halted !== 1'b1) begin bad++; $display("FAIL rh_same v=%b addr=%0d h=%b want 0/2/1", ir_valid, instr_addr, halted); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (ir_valid !== 1'b0 || instr_addr !== 2'd2 || got() !== exp()) begin bad++; $display("FAIL rh_noload%0d v=%b addr=%0d want 0/2", i, ir_valid, instr_addr); end
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    ir_ready = 1'b1;
    repeat (4) step();
    total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL ar_pre v=%b want=1", ir_valid); end
    #2 rst = 1'b1; ref_reset();
    #1;
    total++; if (got() !== 21'd0) begin bad++; $display("FAIL ar_immediate got=%h want=0", got()); end
    rst = 1'b0;
    step();
    step();
    total++; if (ir !== 15'h610A || ir_pc !== 2'd0 || ir_valid !== 1'b1) begin bad++; $display("FAIL ar_restart ir=%h v=%b want 610A v=1", ir, ir_valid); end
  endtask
  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_random();
    test_halt();
    test_redirect_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
